de_ctrl_reg: RTL and testbench

Decode-to-execute control pipeline register and NZCV flags register for the combined ARM/RISC-V core. Captures the decode-stage control bundle (mode, condition, flag-write, write enables, branch type) into the execute stage, with stall (hold) and flush (bubble) support. Also holds the architectural ARM flags: the next-flags value produced by execute-stage condition logic is registered here and returned as the execute-stage current flags.

---
 rtl/cond_pkg.sv | 34 +++
 rtl/flopenrc.sv | 42 ++++
 rtl/de_ctrl_reg.sv | 135 +++++++++++++
 tb/tb_de_ctrl_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared condition/flag definitions and the decode-to-execute control bundle.
// Used by de_ctrl_reg (optional DE_PERF_EN performance counters live in the top).
package cond_pkg;

    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       arm;
        logic [3:0] cond;
        logic [1:0] flagwrite;
        logic       pcsrc;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] branch;
        logic       valid;
    } de_ctrl_t;

    localparam de_ctrl_t DE_CTRL_BUBBLE = '{
        arm:       1'b0,
        cond:      COND_AL,
        flagwrite: 2'b00,
        pcsrc:     1'b0,
        regwrite:  1'b0,
        memwrite:  1'b0,
        branch:    2'b00,
        valid:     1'b0
    };

endpackage

// File: rtl/flopenrc.sv
// Enabled flop with async active-low reset and synchronous clear to a
// parameterised value; clear takes priority over enable.
module flopenrc #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // next-state select: clear, load or hold
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = CLR_VAL;
        end else if (en) begin
            q_d = d;
        end else begin
            q_d = q_q;
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/de_ctrl_reg.sv
// Decode-to-execute control pipeline register plus architectural NZCV flags.
// Optional DE_PERF_EN adds saturating stall/bubble performance counters.
module de_ctrl_reg
    import cond_pkg::*;
`ifdef DE_PERF_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             StallE,
    input  logic             FlushE,
    input  logic             ValidD,
    input  logic             armD,
    input  logic [3:0]       CondD,
    input  logic [1:0]       FlagWriteD,
    input  logic             PCSrcD,
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic [1:0]       BranchD,
    input  logic [3:0]       FlagsD,
    output logic             ValidE,
    output logic             armE,
    output logic [3:0]       CondE,
    output logic [1:0]       FlagWriteE,
    output logic             PCSrcEraw,
    output logic             RegWriteEraw,
    output logic             MemWriteEraw,
    output logic [1:0]       BranchE,
`ifdef DE_PERF_EN
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] BubbleCnt,
`endif
    output logic [3:0]       FlagsE
);

    de_ctrl_t   ctrl_d;
    de_ctrl_t   ctrl_q;
    logic       ctrl_bubble_s;
    logic       flags_en_s;
    logic [3:0] flags_q;

    // assemble the decode bundle and decide when a bubble replaces it
    always_comb begin
        ctrl_d           = DE_CTRL_BUBBLE;
        ctrl_d.arm       = armD;
        ctrl_d.cond      = CondD;
        ctrl_d.flagwrite = FlagWriteD;
        ctrl_d.pcsrc     = PCSrcD;
        ctrl_d.regwrite  = RegWriteD;
        ctrl_d.memwrite  = MemWriteD;
        ctrl_d.branch    = BranchD;
        ctrl_d.valid     = 1'b1;
        // an invalid decode slot only becomes a bubble when E is not held
        ctrl_bubble_s    = FlushE | (~StallE & ~ValidD);
        // flush still lets the departing E instruction commit its flags
        flags_en_s       = ctrl_q.valid & ~StallE;
    end

    flopenrc #(
        .WIDTH   ($bits(de_ctrl_t)),
        .RST_VAL (DE_CTRL_BUBBLE),
        .CLR_VAL (DE_CTRL_BUBBLE)
    ) u_ctrl_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (~StallE),
        .clr     (ctrl_bubble_s),
        .d       (ctrl_d),
        .q       (ctrl_q)
    );

    flopenrc #(
        .WIDTH   (4),
        .RST_VAL (4'b0000),
        .CLR_VAL (4'b0000)
    ) u_flags_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (flags_en_s),
        .clr     (1'b0),
        .d       (FlagsD),
        .q       (flags_q)
    );

    assign ValidE       = ctrl_q.valid;
    assign armE         = ctrl_q.arm;
    assign CondE        = ctrl_q.cond;
    assign FlagWriteE   = ctrl_q.flagwrite;
    assign PCSrcEraw    = ctrl_q.pcsrc;
    assign RegWriteEraw = ctrl_q.regwrite;
    assign MemWriteEraw = ctrl_q.memwrite;
    assign BranchE      = ctrl_q.branch;
    assign FlagsE       = flags_q;

`ifdef DE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;

    // saturating increments for the stall and bubble counters
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (StallE && !FlushE && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ctrl_bubble_s && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_de_ctrl_reg.sv
// Self-checking bench for de_ctrl_reg: directed scenarios then random traffic
// against a behavioural model; counters are checked when DE_PERF_EN is defined.
module tb_de_ctrl_reg;

    logic       clk;
    logic       reset_n;
    logic       StallE, FlushE, ValidD, armD, PCSrcD, RegWriteD, MemWriteD;
    logic [3:0] CondD, FlagsD;
    logic [1:0] FlagWriteD, BranchD;
    logic       ValidE, armE, PCSrcEraw, RegWriteEraw, MemWriteEraw;
    logic [3:0] CondE, FlagsE;
    logic [1:0] FlagWriteE, BranchE;
`ifdef DE_PERF_EN
    logic [31:0] StallCnt, BubbleCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // model: E slot as {valid,arm,cond,flagwrite,pcsrc,regwrite,memwrite,branch}
    localparam logic [12:0] BUBBLE = 13'b0_0_1110_00_0_0_0_00;
    logic [12:0] m_slot;
    logic [3:0]  m_flags;
    int unsigned m_stall_cnt;
    int unsigned m_bubble_cnt;

    de_ctrl_reg dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .ValidD       (ValidD),
        .armD         (armD),
        .CondD        (CondD),
        .FlagWriteD   (FlagWriteD),
        .PCSrcD       (PCSrcD),
        .RegWriteD    (RegWriteD),
        .MemWriteD    (MemWriteD),
        .BranchD      (BranchD),
        .FlagsD       (FlagsD),
        .ValidE       (ValidE),
        .armE         (armE),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .PCSrcEraw    (PCSrcEraw),
        .RegWriteEraw (RegWriteEraw),
        .MemWriteEraw (MemWriteEraw),
        .BranchE      (BranchE),
`ifdef DE_PERF_EN
        .StallCnt     (StallCnt),
        .BubbleCnt    (BubbleCnt),
`endif
        .FlagsE       (FlagsE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_slot       = BUBBLE;
        m_flags      = 4'b0000;
        m_stall_cnt  = 0;
        m_bubble_cnt = 0;
    endtask

    // what one rising edge does to the architectural state
    task automatic model_edge();
        logic bubble;
        if (m_slot[12] && !StallE) m_flags = FlagsD;
        bubble = FlushE || (!StallE && !ValidD);
        if (bubble) begin
            m_slot = BUBBLE;
            if (m_bubble_cnt != 32'hFFFF_FFFF) m_bubble_cnt++;
        end else if (!StallE) begin
            m_slot = {1'b1, armD, CondD, FlagWriteD, PCSrcD, RegWriteD, MemWriteD, BranchD};
        end
        if (StallE && !FlushE && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".ctrl"}, 32'({ValidE, armE, CondE, FlagWriteE, PCSrcEraw,
                                   RegWriteEraw, MemWriteEraw, BranchE}), 32'(m_slot));
        check({tag, ".flags"}, 32'(FlagsE), 32'(m_flags));
`ifdef DE_PERF_EN
        check({tag, ".stallcnt"}, StallCnt, m_stall_cnt);
        check({tag, ".bubblecnt"}, BubbleCnt, m_bubble_cnt);
`endif
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic rand_d();
        armD       = 1'($urandom);
        CondD      = 4'($urandom_range(0, 14));
        FlagWriteD = 2'($urandom);
        PCSrcD     = 1'($urandom);
        RegWriteD  = 1'($urandom);
        MemWriteD  = 1'($urandom);
        BranchD    = 2'($urandom);
        FlagsD     = 4'($urandom);
    endtask

    // asynchronous reset pulse between edges, checked before any edge arrives
    task automatic async_reset(input string tag);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all(tag);
        check({tag, ".cond_al"}, 32'(CondE), 32'h0000_000E);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
        armD = 1'b0; CondD = 4'b0000; FlagWriteD = 2'b00; PCSrcD = 1'b0;
        RegWriteD = 1'b0; MemWriteD = 1'b0; BranchD = 2'b00; FlagsD = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        check("reset.valid", 32'(ValidE), 32'h0);
        check("reset.cond", 32'(CondE), 32'hE);
        #3 reset_n = 1'b1;

        // first load after reset
        ValidD = 1'b1; RegWriteD = 1'b1; CondD = 4'b0000;
        step("load1");
        check("load1.regwrite", 32'(RegWriteEraw), 32'h1);
        check("load1.cond", 32'(CondE), 32'h0);

        // three-cycle stall with changing decode inputs
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_d();
            step("stall");
        end
        check("stall.cond_frozen", 32'(CondE), 32'h0);
`ifdef DE_PERF_EN
        check("stall.cnt3", StallCnt, 32'd3);
`endif

        // flush wins over stall
        FlushE = 1'b1;
        step("stallflush");
        check("stallflush.valid", 32'(ValidE), 32'h0);

        // flags commit on a flush edge, then hold once E is a bubble
        StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b1; rand_d();
        step("reload");
        FlushE = 1'b1; FlagsD = 4'b0110;
        step("flushflags");
        check("flushflags.flags", 32'(FlagsE), 32'h6);
        check("flushflags.valid", 32'(ValidE), 32'h0);
        FlushE = 1'b0; FlagsD = 4'b1111;
        step("flagshold");
        check("flagshold.flags", 32'(FlagsE), 32'h6);

        // stall blocks the flag update until released
        StallE = 1'b1; FlagsD = 4'b1000;
        step("flagstall");
        check("flagstall.flags", 32'(FlagsE), 32'h6);
        StallE = 1'b0; ValidD = 1'b0;
        step("flagrelease");
        check("flagrelease.flags", 32'(FlagsE), 32'h8);

        // reset pulse during a stall
        StallE = 1'b1;
        step("prereset");
        async_reset("midstall");
        StallE = 1'b0; ValidD = 1'b1; rand_d();
        step("postreset");

        // random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            StallE = ($urandom_range(0, 3) == 0);
            FlushE = ($urandom_range(0, 6) == 0);
            ValidD = ($urandom_range(0, 4) != 0);
            rand_d();
            step("rand");
            if ((i % 137) == 136) async_reset("randreset");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
